// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin on contention; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0Valid_i,
  output logic              req0Ready_o,
  input  logic [OP_W-1:0]   req0Op_i,
  input  logic [DATA_W-1:0] req0A_i,
  input  logic [DATA_W-1:0] req0B_i,
  output logic              rsp0Valid_o,
  input  logic              rsp0Ready_i,
  output logic [DATA_W-1:0] rsp0Result_o,
  output logic              rsp0Zero_o,
  input  logic              req1Valid_i,
  output logic              req1Ready_o,
  input  logic [OP_W-1:0]   req1Op_i,
  input  logic [DATA_W-1:0] req1A_i,
  input  logic [DATA_W-1:0] req1B_i,
  output logic              rsp1Valid_o,
  input  logic              rsp1Ready_i,
  output logic [DATA_W-1:0] rsp1Result_o,
  output logic              rsp1Zero_o,
  output logic [OP_W-1:0]   aluControl_o,
  output logic [DATA_W-1:0] aluIn1_o,
  output logic [DATA_W-1:0] aluIn2_o,
  input  logic [DATA_W-1:0] aluResult_i,
  input  logic              aluZero_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(3'b110);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;

  logic                grant_valid_s;
  logic                grant_id_s;
  logic                accept_s;
  logic                rsp_done_s;

  // Winner selection; only meaningful while grant_valid_s is high.
  always_comb begin
    grant_valid_s = req0Valid_i | req1Valid_i;
`ifdef ALU_ARB_RR_EN
    if (req0Valid_i && req1Valid_i) begin
      grant_id_s = ~last_grant_q;
    end else begin
      grant_id_s = req1Valid_i;
    end
`else
    if (req0Valid_i) begin
      grant_id_s = 1'b0;
    end else begin
      grant_id_s = req1Valid_i;
    end
`endif
  end

`ifndef ALU_ARB_RR_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant_q;
`endif

  assign accept_s   = (state_q == IDLE) && grant_valid_s;
  assign rsp_done_s = owner_q ? rsp1Ready_i : rsp0Ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= OP_NOP;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  // Operands are sampled only at the request handshake; the ALU output only at the end of EXEC.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    zero_d       = zero_q;
    if (accept_s) begin
      owner_d      = grant_id_s;
      last_grant_d = grant_id_s;
      op_d         = grant_id_s ? req1Op_i : req0Op_i;
      a_d          = grant_id_s ? req1A_i  : req0A_i;
      b_d          = grant_id_s ? req1B_i  : req0B_i;
    end else if (state_q == EXEC) begin
      result_d = aluResult_i;
      zero_d   = aluZero_i;
    end else begin
      result_d = result_q;
    end
  end

  always_comb begin
    req0Ready_o  = 1'b0;
    req1Ready_o  = 1'b0;
    rsp0Valid_o  = 1'b0;
    rsp1Valid_o  = 1'b0;
    aluControl_o = OP_NOP;
    aluIn1_o     = '0;
    aluIn2_o     = '0;
    case (state_q)
      IDLE: begin
        req0Ready_o = req0Valid_i && !grant_id_s;
        req1Ready_o = req1Valid_i &&  grant_id_s;
      end
      EXEC: begin
        aluControl_o = op_q;
        aluIn1_o     = a_q;
        aluIn2_o     = b_q;
      end
      RESP: begin
        rsp0Valid_o = !owner_q;
        rsp1Valid_o = owner_q;
      end
      default: begin
        aluControl_o = OP_NOP;
      end
    endcase
    rsp0Result_o = owner_q ? '0 : result_q;
    rsp0Zero_o   = owner_q ? 1'b0 : zero_q;
    rsp1Result_o = owner_q ? result_q : '0;
    rsp1Zero_o   = owner_q ? zero_q : 1'b0;
    busy_o       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model, directed scenarios and random traffic.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [2:0]  req0_op, req1_op, alu_ctrl;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [15:0] alu_in1, alu_in2, alu_result;
  logic        alu_zero, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req0Valid_i(req0_valid), .req0Ready_o(req0_ready), .req0Op_i(req0_op),
    .req0A_i(req0_a), .req0B_i(req0_b),
    .rsp0Valid_o(rsp0_valid), .rsp0Ready_i(rsp0_ready),
    .rsp0Result_o(rsp0_result), .rsp0Zero_o(rsp0_zero),
    .req1Valid_i(req1_valid), .req1Ready_o(req1_ready), .req1Op_i(req1_op),
    .req1A_i(req1_a), .req1B_i(req1_b),
    .rsp1Valid_o(rsp1_valid), .rsp1Ready_i(rsp1_ready),
    .rsp1Result_o(rsp1_result), .rsp1Zero_o(rsp1_zero),
    .aluControl_o(alu_ctrl), .aluIn1_o(alu_in1), .aluIn2_o(alu_in2),
    .aluResult_i(alu_result), .aluZero_i(alu_zero), .busy_o(busy)
  );

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return ~b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic zero_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    return (op == 3'b010) && (a == b);
  endfunction

  // Stand-in for the real ALU instance
  assign alu_result = alu_ref(alu_ctrl, alu_in1, alu_in2);
  assign alu_zero   = zero_ref(alu_ctrl, alu_in1, alu_in2);

  function automatic int pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return last ? 0 : 1;
`else
      return 0;
`endif
    end else if (v0) return 0;
    else if (v1) return 1;
    else return -1;
  endfunction

  // Reference model: one op in flight; m_cnt counts cycles since it was accepted.
  logic        m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_zero = 1'b0;
  int          m_cnt = 0;
  logic [2:0]  m_op = 3'b110;
  logic [15:0] m_a = 16'h0, m_b = 16'h0, m_res = 16'h0;

  int          exp_g;
  logic        exp_rdy0, exp_rdy1, exp_vld0, exp_vld1, exp_exec;
  logic [2:0]  exp_ctrl;
  logic [15:0] exp_in1, exp_in2;

  always_comb begin
    exp_g    = pick(req0_valid, req1_valid, m_last);
    exp_rdy0 = !m_busy && (exp_g == 0);
    exp_rdy1 = !m_busy && (exp_g == 1);
    exp_exec = m_busy && (m_cnt == 1);
    exp_ctrl = exp_exec ? m_op : 3'b110;
    exp_in1  = exp_exec ? m_a : 16'h0;
    exp_in2  = exp_exec ? m_b : 16'h0;
    exp_vld0 = m_busy && (m_cnt >= 2) && !m_owner;
    exp_vld1 = m_busy && (m_cnt >= 2) && m_owner;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 0; m_owner <= 1'b0; m_last <= 1'b1;
      m_res <= 16'h0; m_zero <= 1'b0;
    end else if (!m_busy) begin
      if (exp_g >= 0) begin
        m_busy  <= 1'b1;
        m_cnt   <= 1;
        m_owner <= (exp_g == 1);
        m_last  <= (exp_g == 1);
        m_op    <= (exp_g == 1) ? req1_op : req0_op;
        m_a     <= (exp_g == 1) ? req1_a  : req0_a;
        m_b     <= (exp_g == 1) ? req1_b  : req0_b;
      end
    end else if (m_cnt == 1) begin
      m_res  <= alu_ref(m_op, m_a, m_b);
      m_zero <= zero_ref(m_op, m_a, m_b);
      m_cnt  <= 2;
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("req0_ready", 32'(req0_ready), 32'(exp_rdy0));
    check("req1_ready", 32'(req1_ready), 32'(exp_rdy1));
    check("rsp0_valid", 32'(rsp0_valid), 32'(exp_vld0));
    check("rsp1_valid", 32'(rsp1_valid), 32'(exp_vld1));
    check("busy", 32'(busy), 32'(m_busy));
    check("alu_ctrl", 32'(alu_ctrl), 32'(exp_ctrl));
    check("alu_in1", 32'(alu_in1), 32'(exp_in1));
    check("alu_in2", 32'(alu_in2), 32'(exp_in2));
    if (exp_vld0) begin
      check("rsp0_result", 32'(rsp0_result), 32'(m_res));
      check("rsp0_zero", 32'(rsp0_zero), 32'(m_zero));
    end
    if (exp_vld1) begin
      check("rsp1_result", 32'(rsp1_result), 32'(m_res));
      check("rsp1_zero", 32'(rsp1_zero), 32'(m_zero));
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    compare_all();
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req0();
    req0_op = 3'($urandom_range(0, 7));
    req0_a  = 16'($urandom);
    req0_b  = ($urandom_range(0, 3) == 0) ? req0_a : 16'($urandom);
  endtask

  task automatic rand_req1();
    req1_op = 3'($urandom_range(0, 7));
    req1_a  = 16'($urandom);
    req1_b  = ($urandom_range(0, 3) == 0) ? req1_a : 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_neg();
    to_drive();
    rst = 1'b0;
  endtask

  // Single op with literal expectations on latency, ALU drive and result.
  task automatic run_op(input logic x, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic zf, input string tag);
    logic got = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    if (x) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 8; i++) begin
      wait_neg();
      if (x ? exp_rdy1 : exp_rdy0) begin got = 1'b1; break; end
      to_drive();
    end
    check({tag, "_accept_timeout"}, 32'(got), 32'd1);
    to_drive();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_neg();
    check({tag, "_exec_ctrl"}, 32'(alu_ctrl), 32'(op));
    check({tag, "_exec_novalid"}, 32'(x ? rsp1_valid : rsp0_valid), 32'd0);
    to_drive();
    wait_neg();
    check({tag, "_rsp_valid"}, 32'(x ? rsp1_valid : rsp0_valid), 32'd1);
    check({tag, "_other_valid"}, 32'(x ? rsp0_valid : rsp1_valid), 32'd0);
    check({tag, "_result"}, 32'(x ? rsp1_result : rsp0_result), 32'(res));
    check({tag, "_zero"}, 32'(x ? rsp1_zero : rsp0_zero), 32'(zf));
    to_drive();
    wait_neg();
    check({tag, "_ctrl_nop"}, 32'(alu_ctrl), 32'h6);
    to_drive();
  endtask

  initial begin
    int grants[4];
    int hs_cyc[4];
    int nhs;
    logic hs0, hs1;

    rst = 1'b1;
    req0_valid = 1'b0; req0_op = 3'b000; req0_a = 16'h0; req0_b = 16'h0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = 16'h0; req1_b = 16'h0; rsp1_ready = 1'b0;
    to_drive();
    wait_neg();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_result", 32'(rsp0_result), 32'd0);
    check("rst_rsp1_result", 32'(rsp1_result), 32'd0);
    check("rst_zero", 32'({rsp0_zero, rsp1_zero}), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'h6);
    check("rst_alu_in", 32'({alu_in1, alu_in2}), 32'd0);
    to_drive();
    rst = 1'b0;

    run_op(1'b0, 3'b001, 16'h0003, 16'h0004, 16'h0007, 1'b0, "add");
    run_op(1'b1, 3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b1, "sub_eq");
    run_op(1'b0, 3'b101, 16'h1234, 16'h00FF, 16'hFF00, 1'b0, "not");
    run_op(1'b1, 3'b111, 16'h5555, 16'hAAAA, 16'h0000, 1'b0, "op111");

    // Stalled response: result held, req1 readied only after rsp0 handshake
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 16'h0001; req0_b = 16'h0002;
    rsp0_ready = 1'b0;
    wait_neg();
    check("stall_accept", 32'(exp_rdy0), 32'd1);
    to_drive();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 16'h00AA; req1_b = 16'h0000;
    wait_neg();
    to_drive();
    for (int i = 0; i < 5; i++) begin
      wait_neg();
      check("stall_valid", 32'(rsp0_valid), 32'd1);
      check("stall_result", 32'(rsp0_result), 32'h0003);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_req1_ready", 32'(req1_ready), 32'd0);
      to_drive();
    end
    rsp0_ready = 1'b1;
    wait_neg();
    check("stall_release_req1", 32'(req1_ready), 32'd0);
    to_drive();
    wait_neg();
    check("after_release_req1", 32'(req1_ready), 32'd1);
    to_drive();
    req1_valid = 1'b0; rsp1_ready = 1'b1;
    repeat (3) begin wait_neg(); to_drive(); end

    // Reset during EXEC discards the op
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 16'h0010; req0_b = 16'h0020;
    wait_neg();
    to_drive();
    req0_valid = 1'b0;
    rst = 1'b1;
    wait_neg();
    check("rst_exec_ctrl_before", 32'(alu_ctrl), 32'h1);
    to_drive();
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rand_req0(); rand_req1();
    wait_neg();
    check("rst_mid_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("rst_mid_ctrl", 32'(alu_ctrl), 32'h6);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready0", 32'(req0_ready), 32'd1);
    check("rst_mid_ready1", 32'(req1_ready), 32'd0);
    to_drive();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) begin wait_neg(); to_drive(); end

    // Contention: both valid every cycle
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; rand_req0(); rand_req1();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    nhs = 0;
    for (int c = 0; c < 20 && nhs < 4; c++) begin
      wait_neg();
      hs0 = exp_rdy0; hs1 = exp_rdy1;
      if (hs0 || hs1) begin
        grants[nhs] = hs1 ? 1 : 0;
        hs_cyc[nhs] = c;
        nhs++;
      end
      to_drive();
      if (hs0) rand_req0();
      if (hs1) rand_req1();
    end
    check("contention_count", 32'(nhs), 32'd4);
    for (int k = 0; k < nhs; k++) begin
`ifdef ALU_ARB_RR_EN
      check("contention_grant", 32'(grants[k]), 32'(k % 2));
`else
      check("contention_grant", 32'(grants[k]), 32'd0);
`endif
      if (k > 0) check("contention_spacing", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd3);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) begin wait_neg(); to_drive(); end

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      wait_neg();
      hs0 = exp_rdy0 && !rst;
      hs1 = exp_rdy1 && !rst;
      to_drive();
      rst = ($urandom_range(0, 99) == 0);
      if (hs0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 1) == 1);
        rand_req0();
      end else if ($urandom_range(0, 19) == 0) begin
        req0_valid = 1'b0;
      end
      if (hs1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 1) == 1);
        rand_req1();
      end else if ($urandom_range(0, 19) == 0) begin
        req1_valid = 1'b0;
      end
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
    end
    rst = 1'b0;
    wait_neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
